// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the WB register-write arbiter
package wb_arb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
  typedef enum logic {NORMAL, FORCE} wb_arb_state_t;
endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: circular buffer of LLU results with a parallel address-match squash port
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [AW-1:0]                push_addr_i,
  input  logic [DW-1:0]                push_data_i,
  input  logic                         pop_i,
  input  logic                         squash_i,
  input  logic [AW-1:0]                squash_addr_i,
  output logic                         head_valid_o,
  output logic [AW-1:0]                head_addr_o,
  output logic [DW-1:0]                head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   valid_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [PW:0] wp_q, rp_q;
  logic [CW-1:0] cnt;
  assign full_o       = (wp_q - rp_q) == (PW+1)'(DEPTH);
  assign empty_o      = wp_q == rp_q;
  assign head_valid_o = mem_q[rp_q[PW-1:0]].valid;
  assign head_addr_o  = mem_q[rp_q[PW-1:0]].addr;
  assign head_data_o  = mem_q[rp_q[PW-1:0]].data;
  assign valid_cnt_o  = cnt;
  // Popped and squashed slots drop their valid bit, so the valid count is the pending count
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (squash_i && mem_q[i].addr == squash_addr_i) mem_d[i].valid = 1'b0;
      cnt = cnt + CW'(mem_q[i].valid);
    end
    if (pop_i) mem_d[rp_q[PW-1:0]].valid = 1'b0;
    if (push_i) mem_d[wp_q[PW-1:0]] = '{!(squash_i && push_addr_i == squash_addr_i), push_addr_i, push_data_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_q + (PW+1)'(push_i);
      rp_q  <= rp_q + (PW+1)'(pop_i);
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/wb_regwrite_arbiter.sv
// wb_regwrite_arbiter: shares the RF write port between pipeline WB (priority) and buffered LLU results.
// Define WB_ARB_LLU_BYPASS_EN to write an LLU result straight through when the buffer is empty and WB is idle.
module wb_regwrite_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegWrite_WB,
  input  logic [4:0]                 WriteReg_WB,
  input  logic [31:0]                Write_Data_WB,
  input  logic                       llu_valid,
  output logic                       llu_ready,
  input  logic [4:0]                 llu_reg,
  input  logic [31:0]                llu_data,
  output logic                       stall_wb,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);
  localparam int AGW = $clog2(STARVE_LIMIT+1);
  localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT-1);
  wb_arb_state_t st_q, st_d;
  logic [AGW-1:0] age_q, age_d;
  logic busy, force_st, full, empty, head_v, pop, push, squash, bypass;
  logic [AW-1:0] head_a;
  logic [DW-1:0] head_d;
  assign busy      = RegWrite_WB && WriteReg_WB != REG_ZERO;
  assign force_st  = st_q == FORCE;
  assign squash    = busy && !force_st;
  assign llu_ready = !full;
  assign stall_wb  = force_st;
`ifdef WB_ARB_LLU_BYPASS_EN
  assign bypass = empty && !busy && !force_st && llu_valid && llu_reg != REG_ZERO;
`else
  assign bypass = 1'b0;
`endif
  assign push = llu_valid && !full && llu_reg != REG_ZERO && !bypass;
  // Squashed heads leave silently even while WB owns the port
  assign pop  = !empty && (force_st || !busy || !head_v);
  always_comb begin
    rf_we    = squash || (pop && head_v) || bypass;
    rf_waddr = squash ? WriteReg_WB : bypass ? llu_reg : head_a;
    rf_wdata = squash ? Write_Data_WB : bypass ? llu_data : head_d;
    age_d    = (force_st || pop || empty) ? '0 : age_q == AGE_MAX ? age_q : age_q + 1'b1;
    st_d     = (squash && !empty && head_v && age_q == AGE_MAX && head_a != WriteReg_WB) ? FORCE : NORMAL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= NORMAL;
      age_q <= '0;
    end else begin
      st_q  <= st_d;
      age_q <= age_d;
    end
  end
  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .push_i       (push),
    .push_addr_i  (llu_reg),
    .push_data_i  (llu_data),
    .pop_i        (pop),
    .squash_i     (squash),
    .squash_addr_i(WriteReg_WB),
    .head_valid_o (head_v),
    .head_addr_o  (head_a),
    .head_data_o  (head_d),
    .full_o       (full),
    .empty_o      (empty),
    .valid_cnt_o  (pend_cnt)
  );
endmodule
